// File: rtl/yuv2rgb.sv
// -----------------------------------------------------------------------------
// yuv2rgb
//   Inverse colour-space stage: centred YUV (unsigned Y, two's-complement U/V)
//   to full-range unsigned RGB. Fixed 3-stage pipeline with no stall. The
//   data-valid, data-type and metadata sideband travel with each pixel.
//
//   Stage 1 : optional offset stripping, five coefficient products, raw bypass
//   Stage 2 : three channel sums with the +128 rounding term
//   Stage 3 : >>> 8, clamp to [0, 2^PIXEL_WIDTH-1], bypass select, output regs
//
// Parameters
//   PIXEL_WIDTH  bits per channel (8..14)
//   INPUT_OFFSET 1 = input is standard offset YUV (Y+16*S, U/V+half-scale)
//
// Ports
//   clk         rising-edge clock
//   resetb      synchronous active-low reset
//   enable      1 = convert, 0 = bypass (r=y, g=u, b=v); sampled per pixel
//   dvi/dtypei  input data valid / data type
//   y, u, v     input pixel
//   meta_datai  16-bit sideband, passed through untouched
//   dvo/dtypeo  dvi/dtypei delayed by 3 cycles
//   r, g, b     RGB result
//   meta_datao  meta_datai delayed by 3 cycles
// -----------------------------------------------------------------------------
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif

module yuv2rgb #(
  parameter int PIXEL_WIDTH  = 8,
  parameter bit INPUT_OFFSET = 1'b0
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    enable,
  input  logic                    dvi,
  input  logic [`DTYPE_WIDTH-1:0] dtypei,
  input  logic [PIXEL_WIDTH-1:0]  y,
  input  logic [PIXEL_WIDTH-1:0]  u,
  input  logic [PIXEL_WIDTH-1:0]  v,
  input  logic [15:0]             meta_datai,
  output logic                    dvo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [PIXEL_WIDTH-1:0]  r,
  output logic [PIXEL_WIDTH-1:0]  g,
  output logic [PIXEL_WIDTH-1:0]  b,
  output logic [15:0]             meta_datao
);

  localparam int PW  = PIXEL_WIDTH;
  localparam int DW  = `DTYPE_WIDTH;
  localparam int PRW = PW + 11;  // product width
  localparam int SW  = PW + 13;  // sum width, wide enough that no sum can overflow

  // Coefficients, signed with 8 fractional bits
  localparam logic signed [10:0] CY  = 11'sd298;
  localparam logic signed [10:0] CRV = 11'sd409;
  localparam logic signed [10:0] CGU = -11'sd100;
  localparam logic signed [10:0] CGV = -11'sd208;
  localparam logic signed [10:0] CBU = 11'sd516;

  localparam logic [PW-1:0]        Y_OFS = PW'(16 << (PW - 8));
  localparam logic signed [SW-1:0] RND   = SW'(128);
  localparam logic signed [SW-1:0] PMAX  = SW'((1 << PW) - 1);

  // ---------------------------------------------------------------------------
  // Input pre-processing
  // ---------------------------------------------------------------------------
  logic [PW-1:0]        y_p;
  logic signed [PW-1:0] u_p;
  logic signed [PW-1:0] v_p;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    y_p = y;
    u_p = u;
    v_p = v;
    if (INPUT_OFFSET) begin
      // Black level sits at 16*S; anything below it floors at zero.
      y_p = (y >= Y_OFS) ? (y - Y_OFS) : '0;
      // Offset binary to two's complement is just an MSB flip.
      u_p = {~u[PW-1], u[PW-2:0]};
      v_p = {~v[PW-1], v[PW-2:0]};
    end
  end

  // Operands widened to the product width; Y' is zero-extended (unsigned).
  logic signed [PRW-1:0] y_ext;
  logic signed [PRW-1:0] u_ext;
  logic signed [PRW-1:0] v_ext;

  assign y_ext = PRW'($signed({1'b0, y_p}));
  assign u_ext = PRW'(u_p);
  assign v_ext = PRW'(v_p);

  // ---------------------------------------------------------------------------
  // Stage 1: products, raw pixel, mode and sideband
  // ---------------------------------------------------------------------------
  logic signed [PRW-1:0] s1_cy_y, s1_crv_v, s1_cgu_u, s1_cgv_v, s1_cbu_u;
  logic [PW-1:0]         s1_y, s1_u, s1_v;
  logic                  s1_en, s1_dv;
  logic [DW-1:0]         s1_dtype;
  logic [15:0]           s1_meta;

  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge value of its source and stages shift in lock-step.
  // NOTE: reset is synchronous; every pipeline register (data included)
  // clears, so no stale pixel can surface after reset is released.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      s1_cy_y  <= '0;
      s1_crv_v <= '0;
      s1_cgu_u <= '0;
      s1_cgv_v <= '0;
      s1_cbu_u <= '0;
      s1_y     <= '0;
      s1_u     <= '0;
      s1_v     <= '0;
      s1_en    <= 1'b0;
      s1_dv    <= 1'b0;
      s1_dtype <= '0;
      s1_meta  <= '0;
    end else begin
      s1_cy_y  <= y_ext * PRW'(CY);
      s1_crv_v <= v_ext * PRW'(CRV);
      s1_cgu_u <= u_ext * PRW'(CGU);
      s1_cgv_v <= v_ext * PRW'(CGV);
      s1_cbu_u <= u_ext * PRW'(CBU);
      s1_y     <= y;
      s1_u     <= u;
      s1_v     <= v;
      s1_en    <= enable;
      s1_dv    <= dvi;
      s1_dtype <= dtypei;
      s1_meta  <= meta_datai;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: channel sums including the half-LSB rounding term
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] s2_r, s2_g, s2_b;
  logic [PW-1:0]        s2_y, s2_u, s2_v;
  logic                 s2_en, s2_dv;
  logic [DW-1:0]        s2_dtype;
  logic [15:0]          s2_meta;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      s2_r     <= '0;
      s2_g     <= '0;
      s2_b     <= '0;
      s2_y     <= '0;
      s2_u     <= '0;
      s2_v     <= '0;
      s2_en    <= 1'b0;
      s2_dv    <= 1'b0;
      s2_dtype <= '0;
      s2_meta  <= '0;
    end else begin
      s2_r     <= SW'(s1_cy_y) + SW'(s1_crv_v) + RND;
      s2_g     <= SW'(s1_cy_y) + SW'(s1_cgu_u) + SW'(s1_cgv_v) + RND;
      s2_b     <= SW'(s1_cy_y) + SW'(s1_cbu_u) + RND;
      s2_y     <= s1_y;
      s2_u     <= s1_u;
      s2_v     <= s1_v;
      s2_en    <= s1_en;
      s2_dv    <= s1_dv;
      s2_dtype <= s1_dtype;
      s2_meta  <= s1_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: scale down, saturate, bypass select
  // ---------------------------------------------------------------------------
  function automatic logic [PW-1:0] clamp_px(input logic signed [SW-1:0] sum);
    logic signed [SW-1:0] sh;
    sh = sum >>> 8;  // arithmetic: negative results floor
    if (sh[SW-1])
      return '0;
    else if (sh > PMAX)
      return '1;
    else
      return sh[PW-1:0];
  endfunction

  logic [PW-1:0] r_n, g_n, b_n;

  always_comb begin
    r_n = s2_y;
    g_n = s2_u;
    b_n = s2_v;
    if (s2_en) begin
      r_n = clamp_px(s2_r);
      g_n = clamp_px(s2_g);
      b_n = clamp_px(s2_b);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r          <= '0;
      g          <= '0;
      b          <= '0;
      dvo        <= 1'b0;
      dtypeo     <= '0;
      meta_datao <= '0;
    end else begin
      r          <= r_n;
      g          <= g_n;
      b          <= b_n;
      dvo        <= s2_dv;
      dtypeo     <= s2_dtype;
      meta_datao <= s2_meta;
    end
  end

endmodule

// File: tb/tb_yuv2rgb.sv
// -----------------------------------------------------------------------------
// tb_yuv2rgb
//   Bench for yuv2rgb at PIXEL_WIDTH=8. Two instances share the same inputs:
//   one with INPUT_OFFSET=0 and one with INPUT_OFFSET=1. A behavioural model
//   computes each pixel's RGB from the conversion equations with integer
//   arithmetic; every cycle the outputs are compared against the model's
//   result for the pixel captured two edges earlier (zero if a reset edge
//   intervened). Directed pixels with hand-computed results pin the model.
// -----------------------------------------------------------------------------
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif

module tb_yuv2rgb;

  localparam int DW = `DTYPE_WIDTH;

  typedef struct packed {
    logic          dv;
    logic [DW-1:0] dt;
    logic [15:0]   md;
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;
  } out_t;

  logic          clk;
  logic          resetb;
  logic          enable;
  logic          dvi;
  logic [DW-1:0] dtypei;
  logic [7:0]    y, u, v;
  logic [15:0]   meta_datai;

  logic          dvo0, dvo1;
  logic [DW-1:0] dtypeo0, dtypeo1;
  logic [7:0]    r0, g0, b0, r1, g1, b1;
  logic [15:0]   meta0, meta1;

  yuv2rgb #(.PIXEL_WIDTH(8), .INPUT_OFFSET(1'b0)) u_dut (
    .clk(clk), .resetb(resetb), .enable(enable), .dvi(dvi), .dtypei(dtypei),
    .y(y), .u(u), .v(v), .meta_datai(meta_datai),
    .dvo(dvo0), .dtypeo(dtypeo0), .r(r0), .g(g0), .b(b0), .meta_datao(meta0)
  );

  yuv2rgb #(.PIXEL_WIDTH(8), .INPUT_OFFSET(1'b1)) u_dut_ofs (
    .clk(clk), .resetb(resetb), .enable(enable), .dvi(dvi), .dtypei(dtypei),
    .y(y), .u(u), .v(v), .meta_datai(meta_datai),
    .dvo(dvo1), .dtypeo(dtypeo1), .r(r1), .g(g1), .b(b1), .meta_datao(meta1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Scoring
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] sat8(input int x);
    if (x < 0) return 8'd0;
    if (x > 255) return 8'd255;
    return 8'(x);
  endfunction

  function automatic out_t model(input logic dv, input logic [DW-1:0] dt,
                                 input logic [15:0] md, input logic [7:0] yy,
                                 input logic [7:0] uu, input logic [7:0] vv,
                                 input logic en, input bit ofs);
    out_t o;
    int yv, uv, vi;
    o.dv = dv;
    o.dt = dt;
    o.md = md;
    if (!en) begin
      o.r = yy;
      o.g = uu;
      o.b = vv;
      return o;
    end
    if (ofs) begin
      yv = int'(yy) - 16;
      if (yv < 0) yv = 0;
      uv = int'(uu) - 128;
      vi = int'(vv) - 128;
    end else begin
      yv = int'(yy);
      uv = int'($signed(uu));
      vi = int'($signed(vv));
    end
    o.r = sat8((298 * yv + 409 * vi + 128) >>> 8);
    o.g = sat8((298 * yv - 100 * uv - 208 * vi + 128) >>> 8);
    o.b = sat8((298 * yv + 516 * uv + 128) >>> 8);
    return o;
  endfunction

  // Expected output after edge n is the model of the pixel captured at edge
  // n-2, or all zeros if any of edges n-2..n was a reset edge.
  out_t hist0 [8];
  out_t hist1 [8];
  int   edge_n   = 0;
  int   last_rst = 0;
  bit   chk_on   = 1'b0;

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (!resetb) last_rst <= edge_n + 1;
    hist0[(edge_n + 1) % 8] <= model(dvi, dtypei, meta_datai, y, u, v, enable, 1'b0);
    hist1[(edge_n + 1) % 8] <= model(dvi, dtypei, meta_datai, y, u, v, enable, 1'b1);
  end

  always @(posedge clk) begin : compare
    out_t e0, e1;
    #1;
    if (chk_on) begin
      if (edge_n - last_rst <= 2) begin
        e0 = '0;
        e1 = '0;
      end else begin
        e0 = hist0[(edge_n - 2) % 8];
        e1 = hist1[(edge_n - 2) % 8];
      end
      check("stream_plain", {dvo0, dtypeo0, meta0, r0, g0, b0}, e0);
      check("stream_ofs",   {dvo1, dtypeo1, meta1, r1, g1, b1}, e1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [15:0] meta_q = 16'h0100;

  task automatic drive(input logic dv, input logic [7:0] yy, input logic [7:0] uu,
                       input logic [7:0] vv, input logic en);
    @(negedge clk);
    dvi        = dv;
    y          = yy;
    u          = uu;
    v          = vv;
    enable     = en;
    dtypei     = DW'($urandom_range(0, (1 << DW) - 1));
    meta_datai = meta_q;
    meta_q     = meta_q + 16'd1;
  endtask

  // One isolated pixel, then a literal check of its result 3 cycles later.
  task automatic lit(input string nm, input logic [7:0] yy, input logic [7:0] uu,
                     input logic [7:0] vv, input logic en, input bit ofs_dut,
                     input logic [23:0] exp_rgb);
    drive(1'b1, yy, uu, vv, en);
    @(negedge clk);
    dvi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (ofs_dut) begin
      check({nm, "_dv"},  dvo1, 1);
      check({nm, "_rgb"}, {r1, g1, b1}, exp_rgb);
    end else begin
      check({nm, "_dv"},  dvo0, 1);
      check({nm, "_rgb"}, {r0, g0, b0}, exp_rgb);
    end
  endtask

  initial begin
    resetb     = 1'b0;
    enable     = 1'b1;
    dvi        = 1'b0;
    dtypei     = '0;
    y          = '0;
    u          = '0;
    v          = '0;
    meta_datai = '0;

    repeat (3) @(negedge clk);
    check("reset_dvo",  {dvo0, dvo1}, 2'b00);
    check("reset_rgb",  {r0, g0, b0, r1, g1, b1}, 48'd0);
    check("reset_side", {dtypeo0, meta0, dtypeo1, meta1}, '0);
    resetb = 1'b1;
    chk_on = 1'b1;

    // Grey, colour with rounding, clamps
    lit("grey0",    8'd0,   8'd0,   8'd0,  1'b1, 1'b0, {8'd0,   8'd0,   8'd0});
    lit("grey100",  8'd100, 8'd0,   8'd0,  1'b1, 1'b0, {8'd116, 8'd116, 8'd116});
    lit("grey219",  8'd219, 8'd0,   8'd0,  1'b1, 1'b0, {8'd255, 8'd255, 8'd255});
    lit("col_v50",  8'd100, 8'd0,   8'd50, 1'b1, 1'b0, {8'd196, 8'd76,  8'd116});
    lit("col_bclp", 8'd219, 8'd127, 8'd0,  1'b1, 1'b0, {8'd255, 8'd205, 8'd255});
    lit("neg_u",    8'd0,   8'h80,  8'd0,  1'b1, 1'b0, {8'd0,   8'd50,  8'd0});
    lit("neg_v",    8'd0,   8'd0,   8'h80, 1'b1, 1'b0, {8'd0,   8'd104, 8'd0});
    lit("bypass",   8'h12,  8'h34,  8'h56, 1'b0, 1'b0, {8'h12,  8'h34,  8'h56});
    lit("ofs_blk",  8'd16,  8'd128, 8'd128, 1'b1, 1'b1, {8'd0,   8'd0,   8'd0});
    lit("ofs_wht",  8'd235, 8'd128, 8'd128, 1'b1, 1'b1, {8'd255, 8'd255, 8'd255});
    lit("ofs_sub",  8'd5,   8'd128, 8'd128, 1'b1, 1'b1, {8'd0,   8'd0,   8'd0});

    // Enable alternating every pixel, back to back
    for (int i = 0; i < 8; i++)
      drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), i[0]);

    // Random burst with dvi gaps and mostly-convert mode
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 8'($urandom),
            $urandom_range(0, 4) != 0);

    // Reset mid-burst: two pixels in the pipe, a third presented on the reset edge
    drive(1'b1, 8'd200, 8'd10, 8'd20, 1'b1);
    drive(1'b1, 8'd150, 8'd30, 8'd40, 1'b1);
    drive(1'b1, 8'd120, 8'd50, 8'd60, 1'b1);
    resetb = 1'b0;
    @(negedge clk);
    resetb = 1'b1;
    dvi    = 1'b0;
    check("rst_mid_dvo",  {dvo0, dvo1}, 2'b00);
    check("rst_mid_rgb",  {r0, g0, b0, r1, g1, b1}, 48'd0);
    check("rst_mid_side", {dtypeo0, meta0, dtypeo1, meta1}, '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_after_dvo", {dvo0, dvo1}, 2'b00);
    end

    // A second random burst after reset
    for (int i = 0; i < 100; i++)
      drive($urandom_range(0, 1) != 0, 8'($urandom), 8'($urandom), 8'($urandom),
            $urandom_range(0, 1) != 0);

    @(negedge clk);
    dvi = 1'b0;
    repeat (5) @(negedge clk);
    chk_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
